pwm_demod: RTL and testbench

//  Receive end of the dual-rail PWM link driven by the dac pair (pwm_pos/pwm_neg).

---
 rtl/pwm_demod.sv | 218 +++++++++++++++++++++
 tb/tb_pwm_demod.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// ---------------------------------------------------------------------------
// pwm_demod
// This is the receive end of the dual-rail PWM loopback link (pwm_pos/pwm_neg).
// For each 2^N-tick frame it recovers the on-time of both rails and outputs
// the signed difference as a sample. It also flags rising edges that arrive
// at an unexpected phase.
// Optional feature macro: PWM_DEMOD_PERIOD_EN adds a tone-period measurement
// in frames. The measurement is taken between upward sign crossings of the
// sample.
// ---------------------------------------------------------------------------
module pwm_demod #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          pwm_pos,
    input  logic          pwm_neg,
    output logic          locked,
    output logic [N-1:0]  pos_val,
    output logic [N-1:0]  neg_val,
    output logic [N:0]    sample,
    output logic          sample_valid,
    output logic          sync_err,
    output logic [PW-1:0] period,
    output logic          period_valid
);

    localparam logic [0:0]   ST_HUNT   = 1'b0;
    localparam logic [0:0]   ST_LOCKED = 1'b1;
    localparam logic [N-1:0] PH_MAX    = '1;

    logic [0:0]   state_q,        state_d;
    logic [N-1:0] phase_q,        phase_d;
    logic [N-1:0] hi_pos_q,       hi_pos_d;
    logic [N-1:0] hi_neg_q,       hi_neg_d;
    logic         prev_pos_q,     prev_pos_d;
    logic         prev_neg_q,     prev_neg_d;
    logic         locked_q,       locked_d;
    logic [N-1:0] pos_val_q,      pos_val_d;
    logic [N-1:0] neg_val_q,      neg_val_d;
    logic [N:0]   sample_q,       sample_d;
    logic         sample_valid_q, sample_valid_d;
    logic         sync_err_q,     sync_err_d;

    logic         rise_c;
    logic [N-1:0] inc_pos_c;
    logic [N-1:0] inc_neg_c;

    // Rail edge detection and saturating on-time increments for this tick
    always_comb begin
        rise_c    = (pwm_pos & ~prev_pos_q) | (pwm_neg & ~prev_neg_q);
        inc_pos_c = (hi_pos_q == PH_MAX) ? PH_MAX : hi_pos_q + N'(pwm_pos);
        inc_neg_c = (hi_neg_q == PH_MAX) ? PH_MAX : hi_neg_q + N'(pwm_neg);
    end

    // Next-state and output logic: frame tracking, counting, result capture
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        hi_pos_d       = hi_pos_q;
        hi_neg_d       = hi_neg_q;
        prev_pos_d     = prev_pos_q;
        prev_neg_d     = prev_neg_q;
        pos_val_d      = pos_val_q;
        neg_val_d      = neg_val_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        sync_err_d     = 1'b0;

        if (tick) begin
            prev_pos_d = pwm_pos;
            prev_neg_d = pwm_neg;
            case (state_q)
                ST_HUNT: begin
                    // First rise defines phase 0; this tick already counts
                    if (rise_c) begin
                        state_d  = ST_LOCKED;
                        phase_d  = N'(1);
                        hi_pos_d = N'(pwm_pos);
                        hi_neg_d = N'(pwm_neg);
                    end
                end
                ST_LOCKED: begin
                    if (rise_c && (phase_q != '0)) begin
                        // Misplaced edge: drop the partial frame, restart on it
                        sync_err_d = 1'b1;
                        phase_d    = N'(1);
                        hi_pos_d   = N'(pwm_pos);
                        hi_neg_d   = N'(pwm_neg);
                    end else begin
                        phase_d = phase_q + N'(1);
                        if (phase_q == PH_MAX) begin
                            pos_val_d      = inc_pos_c;
                            neg_val_d      = inc_neg_c;
                            sample_d       = {1'b0, inc_pos_c} - {1'b0, inc_neg_c};
                            sample_valid_d = 1'b1;
                            hi_pos_d       = '0;
                            hi_neg_d       = '0;
                        end else begin
                            hi_pos_d = inc_pos_c;
                            hi_neg_d = inc_neg_c;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_HUNT;
            phase_q        <= '0;
            hi_pos_q       <= '0;
            hi_neg_q       <= '0;
            prev_pos_q     <= 1'b0;
            prev_neg_q     <= 1'b0;
            locked_q       <= 1'b0;
            pos_val_q      <= '0;
            neg_val_q      <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            hi_pos_q       <= hi_pos_d;
            hi_neg_q       <= hi_neg_d;
            prev_pos_q     <= prev_pos_d;
            prev_neg_q     <= prev_neg_d;
            locked_q       <= locked_d;
            pos_val_q      <= pos_val_d;
            neg_val_q      <= neg_val_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign locked       = locked_q;
    assign pos_val      = pos_val_q;
    assign neg_val      = neg_val_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign sync_err     = sync_err_q;

`ifdef PWM_DEMOD_PERIOD_EN
    logic          restart_c;
    logic          gt0_c;
    logic [PW-1:0] frm_cnt_q,      frm_cnt_d;
    logic [PW-1:0] period_q,       period_d;
    logic          period_valid_q, period_valid_d;
    logic          armed_q,        armed_d;
    logic          last_gt0_q,     last_gt0_d;

    // Frame phase restarts on lock or sync error; period history is void then
    assign restart_c = tick & rise_c & ((state_q == ST_HUNT) | (phase_q != '0));
    assign gt0_c     = ~sample_d[N] & (sample_d != '0);

    // Period measurement between upward sign crossings of the sample
    always_comb begin
        frm_cnt_d      = frm_cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        armed_d        = armed_q;
        last_gt0_d     = last_gt0_q;

        if (restart_c) begin
            frm_cnt_d  = '0;
            armed_d    = 1'b0;
            last_gt0_d = 1'b0;
        end else if (sample_valid_d) begin
            if (gt0_c && !last_gt0_q) begin
                if (armed_q) begin
                    period_d       = frm_cnt_q;
                    period_valid_d = 1'b1;
                end
                armed_d   = 1'b1;
                frm_cnt_d = PW'(1);
            end else if (frm_cnt_q != '1) begin
                frm_cnt_d = frm_cnt_q + PW'(1);
            end
            last_gt0_d = gt0_c;
        end
    end

    // Period registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frm_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            armed_q        <= 1'b0;
            last_gt0_q     <= 1'b0;
        end else begin
            frm_cnt_q      <= frm_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            armed_q        <= armed_d;
            last_gt0_q     <= last_gt0_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_demod.sv
// ---------------------------------------------------------------------------
// tb_pwm_demod
// Directed bench for pwm_demod with N=4 (16-tick frames). It generates PWM
// frames tick by tick, counts the DUT pulses, and compares the results with
// values computed by hand.
// ---------------------------------------------------------------------------
module tb_pwm_demod;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        pwm_pos;
    logic        pwm_neg;
    logic        locked;
    logic [3:0]  pos_val;
    logic [3:0]  neg_val;
    logic [4:0]  sample;
    logic        sample_valid;
    logic        sync_err;
    logic [11:0] period;
    logic        period_valid;

    int checks;
    int errors;
    int nvalid;
    int nsync;
    int nwide;
    int npv;
    int total_pv;
    int tick_idx;
    int last_valid_tick;
    int last_period;
    logic vld_prev;

    pwm_demod #(.N(4), .PW(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .pwm_pos      (pwm_pos),
        .pwm_neg      (pwm_neg),
        .locked       (locked),
        .pos_val      (pos_val),
        .neg_val      (neg_val),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sync_err     (sync_err),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    // Single comparison point: count and report mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        nvalid          = 0;
        nsync           = 0;
        nwide           = 0;
        npv             = 0;
        tick_idx        = 0;
        last_valid_tick = -1;
        last_period     = 0;
    endtask

    // One clock: drive on falling edge, observe 1ns after the rising edge
    task automatic step(input logic t, input logic p, input logic n);
        @(negedge clk);
        tick    = t;
        pwm_pos = p;
        pwm_neg = n;
        @(posedge clk);
        #1;
        if (t) tick_idx++;
        if (sample_valid) begin
            nvalid++;
            last_valid_tick = tick_idx;
            if (vld_prev) nwide++;
        end
        vld_prev = sample_valid;
        if (sync_err) nsync++;
        if (period_valid) begin
            npv++;
            total_pv++;
            last_period = int'(period);
        end
    endtask

    // Frame phases [first,last) with given on-times; gap idle clocks per tick
    task automatic frame(input int tp, input int tn, input int gap, input int first, input int last);
        for (int k = first; k < last; k++) begin
            for (int g = 0; g < gap; g++) step(1'b0, k < tp, k < tn);
            step(1'b1, k < tp, k < tn);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        tick    = 1'b0;
        pwm_pos = 1'b0;
        pwm_neg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vld_prev = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_pos"},    32'(pos_val), 32'd0);
        chk({tag, "_neg"},    32'(neg_val), 32'd0);
        chk({tag, "_sample"}, 32'(sample), 32'd0);
        chk({tag, "_valid"},  32'(sample_valid), 32'd0);
        chk({tag, "_serr"},   32'(sync_err), 32'd0);
        chk({tag, "_period"}, 32'(period), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        tick     = 1'b0;
        pwm_pos  = 1'b0;
        pwm_neg  = 1'b0;
        checks   = 0;
        errors   = 0;
        total_pv = 0;
        vld_prev = 1'b0;
        clear_stats();

        // Reset state
        do_reset();
        chk_zero("rst");
        release_reset();

        // 1: pos t_on=5, neg 0, three frames
        clear_stats();
        frame(5, 0, 0, 0, 1);
        chk("t1_lock", 32'(locked), 32'd1);
        frame(5, 0, 0, 1, 16);
        frame(5, 0, 0, 0, 16);
        frame(5, 0, 0, 0, 16);
        chk("t1_nvalid", nvalid, 3);
        chk("t1_vtick",  last_valid_tick, 48);
        chk("t1_pos",    32'(pos_val), 32'd5);
        chk("t1_neg",    32'(neg_val), 32'd0);
        chk("t1_sample", 32'(sample), 32'h05);
        chk("t1_nsync",  nsync, 0);

        // 2: neg t_on=15 gives -15; idle rails never lock
        do_reset();
        release_reset();
        clear_stats();
        frame(0, 15, 0, 0, 16);
        frame(0, 15, 0, 0, 16);
        chk("t2_nvalid", nvalid, 2);
        chk("t2_pos",    32'(pos_val), 32'd0);
        chk("t2_neg",    32'(neg_val), 32'd15);
        chk("t2_sample", 32'(sample), 32'h11);
        chk("t2_nsync",  nsync, 0);
        do_reset();
        release_reset();
        clear_stats();
        for (int f = 0; f < 4; f++) frame(0, 0, 0, 0, 16);
        chk("t2_nolock",  32'(locked), 32'd0);
        chk("t2_novalid", nvalid, 0);

        // 3: extra rise at phase 9 restarts the frame with a sync error
        do_reset();
        release_reset();
        clear_stats();
        frame(7, 0, 0, 0, 16);
        frame(7, 0, 0, 0, 9);
        frame(7, 0, 0, 0, 16);
        chk("t3_nsync",  nsync, 1);
        chk("t3_nvalid", nvalid, 2);
        chk("t3_vtick",  last_valid_tick, 41);
        chk("t3_pos",    32'(pos_val), 32'd7);
        chk("t3_sample", 32'(sample), 32'h07);
        chk("t3_lock",   32'(locked), 32'd1);

        // 4: tick every third clock
        do_reset();
        release_reset();
        clear_stats();
        frame(3, 0, 2, 0, 16);
        frame(3, 0, 2, 0, 16);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_nvalid", nvalid, 2);
        chk("t4_vtick",  last_valid_tick, 32);
        chk("t4_pos",    32'(pos_val), 32'd3);
        chk("t4_sample", 32'(sample), 32'h03);
        chk("t4_width",  nwide, 0);

        // 5: reset in mid-frame, then relock
        do_reset();
        release_reset();
        clear_stats();
        frame(5, 0, 0, 0, 16);
        frame(5, 0, 0, 0, 8);
        chk("t5_pre", nvalid, 1);
        do_reset();
        chk_zero("t5_rst");
        release_reset();
        clear_stats();
        frame(5, 0, 0, 0, 1);
        chk("t5_relock", 32'(locked), 32'd1);
        frame(5, 0, 0, 1, 16);
        chk("t5_nvalid", nvalid, 1);
        chk("t5_vtick",  last_valid_tick, 16);
        chk("t5_pos",    32'(pos_val), 32'd5);

        // 6: tone period from sample sign sequence
`ifdef PWM_DEMOD_PERIOD_EN
        do_reset();
        release_reset();
        clear_stats();
        for (int f = 0; f < 11; f++) begin
            if (f == 0 || f == 1 || f == 5 || f == 6 || f == 10)
                frame(5, 0, 0, 0, 16);
            else
                frame(0, 5, 0, 0, 16);
        end
        chk("t6_nvalid", nvalid, 11);
        chk("t6_npv",    npv, 2);
        chk("t6_lastp",  last_period, 5);
        chk("t6_period", 32'(period), 32'd5);
`else
        chk("t6_period", 32'(period), 32'd0);
        chk("t6_npv",    total_pv, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
